// File: rtl/cordic_vect_sched.sv
// Round-robin scheduler sharing one circular-vectoring CORDIC between NUM_REQ clients.
// A watchdog resets the CORDIC and returns an error ack if done never arrives.
module cordic_vect_sched #(
  parameter int IO_WIDTH = 18,
  parameter int NUM_REQ  = 3,
  parameter int TIMEOUT  = 64,
  parameter int TO_WIDTH = 8
) (
  input  logic                         sys_clk_i,
  input  logic                         reset_n_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  x_req_i,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  y_req_i,
  output logic [NUM_REQ-1:0]           ack_o,
  output logic [IO_WIDTH-1:0]          mag_o,
  output logic [IO_WIDTH-1:0]          ang_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic                         cor_start_o,
  output logic [IO_WIDTH-1:0]          cor_x_o,
  output logic [IO_WIDTH-1:0]          cor_y_o,
  output logic                         cor_rst_o,
  input  logic                         cor_done_i,
  input  logic [IO_WIDTH-1:0]          cor_x_i,
  input  logic [IO_WIDTH-1:0]          cor_theta_i
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        grant_q, grant_d;
  logic [TO_WIDTH-1:0]  wd_q, wd_d;
  logic [IO_WIDTH-1:0]  cor_x_q, cor_x_d;
  logic [IO_WIDTH-1:0]  cor_y_q, cor_y_d;
  logic [IO_WIDTH-1:0]  mag_q, mag_d;
  logic [IO_WIDTH-1:0]  ang_q, ang_d;
  logic                 err_flag_q, err_flag_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 cor_start_q, cor_start_d;
  logic                 cor_rst_q, cor_rst_d;

  logic [IO_WIDTH-1:0]  x_arr [NUM_REQ];
  logic [IO_WIDTH-1:0]  y_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign x_arr[gi] = x_req_i[gi*IO_WIDTH +: IO_WIDTH];
      assign y_arr[gi] = y_req_i[gi*IO_WIDTH +: IO_WIDTH];
    end
  endgenerate

  // Round-robin search starting at rr_ptr; first requester found wins.
  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    wd_d        = wd_q;
    cor_x_d     = cor_x_q;
    cor_y_d     = cor_y_q;
    mag_d       = mag_q;
    ang_d       = ang_q;
    err_flag_d  = err_flag_q;
    err_d       = 1'b0;
    ack_d       = '0;
    cor_start_d = 1'b0;
    cor_rst_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The ack cycle is spent in IDLE; skipping arbitration here keeps the
        // just-served client from being re-granted on its still-high request.
        if (found && (ack_q == '0)) begin
          grant_d     = sel;
          cor_x_d     = x_arr[sel];
          cor_y_d     = y_arr[sel];
          cor_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (cor_done_i) begin
          mag_d      = cor_x_i;
          ang_d      = cor_theta_i;
          err_flag_d = 1'b0;
          state_d    = RESP;
        end else if (wd_q == TO_WIDTH'(TIMEOUT - 1)) begin
          cor_rst_d  = 1'b1;
          mag_d      = '0;
          ang_d      = '0;
          err_flag_d = 1'b1;
          state_d    = RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RESP: begin
        ack_d[grant_q] = 1'b1;
        err_d          = err_flag_q;
        rr_ptr_d       = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      wd_q        <= '0;
      cor_x_q     <= '0;
      cor_y_q     <= '0;
      mag_q       <= '0;
      ang_q       <= '0;
      err_flag_q  <= 1'b0;
      err_q       <= 1'b0;
      ack_q       <= '0;
      cor_start_q <= 1'b0;
      cor_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      wd_q        <= wd_d;
      cor_x_q     <= cor_x_d;
      cor_y_q     <= cor_y_d;
      mag_q       <= mag_d;
      ang_q       <= ang_d;
      err_flag_q  <= err_flag_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
      cor_start_q <= cor_start_d;
      cor_rst_q   <= cor_rst_d;
    end
  end

  assign ack_o       = ack_q;
  assign mag_o       = mag_q;
  assign ang_o       = ang_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != IDLE);
  assign cor_start_o = cor_start_q;
  assign cor_x_o     = cor_x_q;
  assign cor_y_o     = cor_y_q;
  assign cor_rst_o   = cor_rst_q;

endmodule

// File: tb/tb_cordic_vect_sched.sv
// Bench for cordic_vect_sched: behavioural CORDIC with programmable latency plus
// a scoreboard of expected (client, operands, results) in predicted grant order.
module tb_cordic_vect_sched;

  localparam int W  = 18;
  localparam int N  = 3;
  localparam int TO = 64;

  logic           sys_clk_i;
  logic           reset_n_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] x_req_i;
  logic [N*W-1:0] y_req_i;
  logic [N-1:0]   ack_o;
  logic [W-1:0]   mag_o, ang_o;
  logic           err_o, busy_o, cor_start_o, cor_rst_o;
  logic [W-1:0]   cor_x_o, cor_y_o;
  logic           cor_done_i;
  logic [W-1:0]   cor_x_i, cor_theta_i;

  cordic_vect_sched #(.IO_WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .sys_clk_i   (sys_clk_i),
    .reset_n_i   (reset_n_i),
    .req_i       (req_i),
    .x_req_i     (x_req_i),
    .y_req_i     (y_req_i),
    .ack_o       (ack_o),
    .mag_o       (mag_o),
    .ang_o       (ang_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .cor_start_o (cor_start_o),
    .cor_x_o     (cor_x_o),
    .cor_y_o     (cor_y_o),
    .cor_rst_o   (cor_rst_o),
    .cor_done_i  (cor_done_i),
    .cor_x_i     (cor_x_i),
    .cor_theta_i (cor_theta_i)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  typedef struct {
    int           client;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] mag;
    logic [W-1:0] ang;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   vecs, miscmp, cyc;
  int   issued[N];
  int   done_cnt[N];
  int   lat;
  int   last_start_cyc, last_rst_cyc, last_ack_cyc, ack_total, rst_total;
  logic prev_start;

  function automatic logic [W-1:0] opx(int c, int n);
    return W'(4096 + c*9029 + n*1329);
  endfunction

  function automatic logic [W-1:0] opy(int c, int n);
    return W'(c*4369 - n*1911);
  endfunction

  // Scaled magnitude the CORDIC stand-in reports: x - x/256 (0x1000 -> 0xFF0).
  function automatic logic [W-1:0] cordic_mag(logic [W-1:0] x);
    logic signed [W-1:0] xs;
    xs = x;
    return W'(xs - (xs >>> 8));
  endfunction

  function automatic void push(int c, int n, logic e);
    exp_t t;
    t.client = c;
    t.x      = opx(c, n);
    t.y      = opy(c, n);
    t.mag    = e ? '0 : cordic_mag(t.x);
    t.ang    = e ? '0 : t.y;
    t.err    = e;
    sb.push_back(t);
  endfunction

  always_comb begin
    x_req_i = '0;
    y_req_i = '0;
    for (int c = 0; c < N; c++) begin
      x_req_i[c*W +: W] = opx(c, done_cnt[c]);
      y_req_i[c*W +: W] = opy(c, done_cnt[c]);
    end
  end

  // CORDIC stand-in: done rises lat cycles after start rises; lat==0 never answers.
  int                 m_cnt;
  logic signed [W-1:0] m_x, m_y;
  always @(posedge sys_clk_i) begin
    if (!reset_n_i || cor_rst_o) begin
      m_cnt      <= 0;
      cor_done_i <= 1'b0;
    end else begin
      cor_done_i <= (m_cnt == 1);
      if (m_cnt == 1) begin
        cor_x_i     <= cordic_mag(m_x);
        cor_theta_i <= m_y;
      end
      if (cor_start_o) begin
        m_cnt <= (lat == 0) ? 0 : lat - 1;
        m_x   <= cor_x_o;
        m_y   <= cor_y_o;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic wait_drain(string name);
    int i;
    i = 0;
    while (sb.size() != 0 && i < 3000) begin
      @(posedge sys_clk_i);
      i++;
    end
    vecs++;
    if (sb.size() != 0) begin
      miscmp++;
      $display("FAIL %s_drain: %0d transactions outstanding, required 0", name, sb.size());
    end
    repeat (2) @(posedge sys_clk_i);
    #2;
  endtask

  task automatic test_reset();
    logic [78:0] outs;
    reset_n_i = 1'b0;
    req_i     = '0;
    lat       = 17;
    #1;
    outs = {ack_o, mag_o, ang_o, err_o, busy_o, cor_start_o, cor_x_o, cor_y_o, cor_rst_o};
    vecs++;
    if (outs !== '0) begin
      miscmp++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    repeat (3) @(posedge sys_clk_i);
    #2 reset_n_i = 1'b1;
    @(posedge sys_clk_i);
    #2;
    outs = {ack_o, mag_o, ang_o, err_o, busy_o, cor_start_o, cor_x_o, cor_y_o, cor_rst_o};
    vecs++;
    if (outs !== '0) begin
      miscmp++;
      $display("FAIL post_release_outputs: got %h, required 0", outs);
    end
  endtask

  task automatic test_basic();
    int c0;
    lat = 17;
    c0  = cyc;
    push(0, done_cnt[0], 1'b0);
    issued[0]++;
    req_i[0] = 1'b1;
    wait_drain("basic");
    vecs++;
    if (last_start_cyc - c0 != 1) begin
      miscmp++;
      $display("FAIL basic_start_latency: got %0d, required 1", last_start_cyc - c0);
    end
    vecs++;
    if (last_ack_cyc - c0 != 20) begin
      miscmp++;
      $display("FAIL basic_ack_latency: got %0d, required 20", last_ack_cyc - c0);
    end
  endtask

  task automatic reset_dut();
    reset_n_i = 1'b0;
    req_i     = '0;
    for (int c = 0; c < N; c++) issued[c] = done_cnt[c];
    repeat (3) @(posedge sys_clk_i);
    #2 reset_n_i = 1'b1;
    @(posedge sys_clk_i);
    #2;
  endtask

  task automatic test_round_robin();
    reset_dut();
    lat = 5;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < N; c++) push(c, done_cnt[c] + r, 1'b0);
    for (int c = 0; c < N; c++) issued[c] += 2;
    req_i = 3'b111;
    wait_drain("round_robin");
  endtask

  task automatic test_wrap();
    lat = 5;
    push(1, done_cnt[1], 1'b0);
    issued[1]++;
    req_i[1] = 1'b1;
    wait_drain("wrap_first");
    push(0, done_cnt[0], 1'b0);
    push(1, done_cnt[1], 1'b0);
    issued[0]++;
    issued[1]++;
    req_i = 3'b011;
    wait_drain("wrap_pair");
  endtask

  task automatic test_timeout();
    int r0;
    lat = 0;
    r0  = rst_total;
    push(1, done_cnt[1], 1'b1);
    issued[1]++;
    req_i[1] = 1'b1;
    wait_drain("timeout");
    vecs++;
    if (rst_total != r0 + 1) begin
      miscmp++;
      $display("FAIL timeout_rst_count: got %0d, required %0d", rst_total - r0, 1);
    end
    vecs++;
    if (last_rst_cyc - last_start_cyc != TO + 1) begin
      miscmp++;
      $display("FAIL timeout_rst_delay: got %0d, required %0d", last_rst_cyc - last_start_cyc, TO + 1);
    end
    vecs++;
    if (last_ack_cyc - last_rst_cyc != 1) begin
      miscmp++;
      $display("FAIL timeout_ack_after_rst: got %0d, required 1", last_ack_cyc - last_rst_cyc);
    end
    lat = 17;
    push(1, done_cnt[1], 1'b0);
    issued[1]++;
    req_i[1] = 1'b1;
    wait_drain("after_timeout");
  endtask

  task automatic test_done_at_expiry();
    int r0;
    lat = TO;
    r0  = rst_total;
    push(1, done_cnt[1], 1'b0);
    issued[1]++;
    req_i[1] = 1'b1;
    wait_drain("expiry");
    vecs++;
    if (rst_total != r0) begin
      miscmp++;
      $display("FAIL expiry_no_rst: got %0d pulses, required 0", rst_total - r0);
    end
    vecs++;
    if (last_ack_cyc - last_start_cyc != TO + 2) begin
      miscmp++;
      $display("FAIL expiry_latency: got %0d, required %0d", last_ack_cyc - last_start_cyc, TO + 2);
    end
  endtask

  task automatic test_reset_mid();
    int a0, r0;
    logic [78:0] outs;
    lat = 17;
    push(0, done_cnt[0], 1'b0);
    issued[0]++;
    req_i[0] = 1'b1;
    repeat (8) @(posedge sys_clk_i);
    #2 reset_n_i = 1'b0;
    #1;
    outs = {ack_o, mag_o, ang_o, err_o, busy_o, cor_start_o, cor_x_o, cor_y_o, cor_rst_o};
    vecs++;
    if (outs !== '0) begin
      miscmp++;
      $display("FAIL midreset_outputs: got %h, required 0", outs);
    end
    issued[0] = done_cnt[0];
    req_i     = '0;
    a0 = ack_total;
    r0 = rst_total;
    repeat (3) @(posedge sys_clk_i);
    #2 reset_n_i = 1'b1;
    repeat (25) @(posedge sys_clk_i);
    #2;
    vecs++;
    if (ack_total != a0 || rst_total != r0) begin
      miscmp++;
      $display("FAIL midreset_quiet: got %0d acks %0d rsts, required 0 0", ack_total - a0, rst_total - r0);
    end
    // rr_ptr must restart at 0, so client 1 precedes client 2.
    push(1, done_cnt[1], 1'b0);
    push(2, done_cnt[2], 1'b0);
    issued[1]++;
    issued[2]++;
    req_i = 3'b110;
    wait_drain("after_midreset");
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs = 0; miscmp = 0; cyc = 0; lat = 17;
    last_start_cyc = 0; last_rst_cyc = 0; last_ack_cyc = 0;
    ack_total = 0; rst_total = 0; prev_start = 1'b0;
    for (int c = 0; c < N; c++) begin
      issued[c]   = 0;
      done_cnt[c] = 0;
    end
    reset_n_i = 1'b0;
    req_i     = '0;

    fork
      begin : monitor
        exp_t        e;
        logic [N-1:0] exp_ack;
        int          ci;
        forever begin
          @(posedge sys_clk_i);
          cyc++;
          #1;
          if (!reset_n_i) begin
            sb.delete();
            prev_start = 1'b0;
          end else begin
            if (cor_start_o) begin
              last_start_cyc = cyc;
              vecs++;
              if (prev_start || sb.size() == 0 || cor_x_o !== sb[0].x || cor_y_o !== sb[0].y) begin
                miscmp++;
                $display("FAIL start_operands: got x=%h y=%h repeat=%0b, required x=%h y=%h",
                         cor_x_o, cor_y_o, prev_start,
                         (sb.size() != 0) ? sb[0].x : '0, (sb.size() != 0) ? sb[0].y : '0);
              end
            end
            prev_start = cor_start_o;
            if (cor_rst_o) begin
              rst_total++;
              last_rst_cyc = cyc;
              vecs++;
              if (sb.size() == 0 || sb[0].err !== 1'b1) begin
                miscmp++;
                $display("FAIL cor_rst: got pulse at cycle %0d, required none", cyc);
              end
            end
            if (ack_o != '0) begin
              ack_total++;
              last_ack_cyc = cyc;
              ci = 0;
              for (int k = 0; k < N; k++) if (ack_o[k]) ci = k;
              vecs++;
              if (sb.size() == 0) begin
                miscmp++;
                $display("FAIL ack_unexpected: got ack=%b, required none", ack_o);
              end else begin
                e = sb.pop_front();
                exp_ack = N'(1 << e.client);
                if (ack_o !== exp_ack || mag_o !== e.mag || ang_o !== e.ang || err_o !== e.err) begin
                  miscmp++;
                  $display("FAIL ack_result: got ack=%b mag=%h ang=%h err=%b, required ack=%b mag=%h ang=%h err=%b",
                           ack_o, mag_o, ang_o, err_o, exp_ack, e.mag, e.ang, e.err);
                end
              end
              $display("txn: ack=%b mag=%h ang=%h err=%b cycle=%0d", ack_o, mag_o, ang_o, err_o, cyc);
              done_cnt[ci]++;
              req_i[ci] = (issued[ci] != done_cnt[ci]);
            end
          end
        end
      end
    join_none

    test_reset();
    test_basic();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_done_at_expiry();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
